// File: rtl/sdram_rd.sv
// -----------------------------------------------------------------------------
// sdram_rd
// Read-path sub-controller of the SDRAM controller. Takes one user read
// request, requests the bus from the arbiter, drives ACTIVE -> READ ->
// PRECHARGE, captures the returning burst after CAS latency and releases the
// bus with rd_end once the dq bus is quiet and tRP is met.
//
// Ports
//   rd_clk, rd_rst_n     clock, synchronous active-low reset
//   init_end             SDRAM initialisation complete (level)
//   rd_trig, rd_addr_in  user read request pulse, {bank, row, col}
//   rd_en, rd_req        arbiter grant / bus request
//   rd_end, rd_busy      transaction done pulse / transaction in progress
//   rd_cmd, rd_bank,
//   rd_addr              SDRAM command {cs_n, ras_n, cas_n, we_n}, bank, address
//   sdram_dq_in          SDRAM data bus, input side
//   rd_data,
//   rd_data_valid        captured read word stream
// -----------------------------------------------------------------------------
module sdram_rd #(
   parameter int unsigned CAS_LAT   = 3,
   parameter int unsigned TRCD      = 2,
   parameter int unsigned TRP       = 2,
   parameter int unsigned BURST_LEN = 8
) (
   input  logic        rd_clk,
   input  logic        rd_rst_n,
   input  logic        init_end,
   input  logic        rd_trig,
   input  logic [23:0] rd_addr_in,
   input  logic        rd_en,
   input  logic [15:0] sdram_dq_in,
   output logic        rd_req,
   output logic        rd_end,
   output logic [3:0]  rd_cmd,
   output logic [1:0]  rd_bank,
   output logic [12:0] rd_addr,
   output logic [15:0] rd_data,
   output logic        rd_data_valid,
   output logic        rd_busy
);

   localparam logic [3:0] CMD_NOP = 4'b0111;
   localparam logic [3:0] CMD_ACT = 4'b0011;
   localparam logic [3:0] CMD_RD  = 4'b0101;
   localparam logic [3:0] CMD_PRE = 4'b0010;

   // Release distance after PRECHARGE: tRP, or long enough for the last
   // word to leave the dq bus, whichever is later.
   localparam int unsigned REL_DLY  = (TRP > CAS_LAT + 1) ? TRP : CAS_LAT + 1;
   localparam logic [9:0]  RCD_LAST = 10'((TRCD >= 2) ? TRCD - 2 : 0);
   localparam logic [9:0]  BST_LAST = 10'((BURST_LEN >= 2) ? BURST_LEN - 2 : 0);
   localparam logic [9:0]  RP_LAST  = 10'(REL_DLY - 2);
   localparam logic [9:0]  VLD_LOAD = 10'(BURST_LEN - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_REQ, S_ACT, S_RCD, S_READ, S_BURST, S_PRE, S_RP, S_END
   } state_t;

   state_t             state, next_state;
   logic [9:0]         cnt;
   logic [23:0]        addr_q;
   logic               grant;
   logic               counting;
   logic [3:0]         cmd_d;
   logic [1:0]         bank_d;
   logic [12:0]        addr_d;
   logic [CAS_LAT-1:0] lat_sr;
   logic [9:0]         vld_cnt;
   logic               cap_en;

   // Grant is only honoured once our request is actually visible on rd_req.
   assign grant    = (state == S_REQ) && rd_req && rd_en;
   assign counting = (state == S_RCD) || (state == S_BURST) || (state == S_RP);

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:  if (rd_trig && init_end) next_state = S_REQ;
         S_REQ:   if (grant) next_state = S_ACT;
         S_ACT:   next_state = (TRCD == 1) ? S_READ : S_RCD;
         S_RCD:   if (cnt == RCD_LAST) next_state = S_READ;
         S_READ:  next_state = (BURST_LEN == 1) ? S_PRE : S_BURST;
         S_BURST: if (cnt == BST_LAST) next_state = S_PRE;
         S_PRE:   next_state = S_RP;
         S_RP:    if (cnt == RP_LAST) next_state = S_END;
         S_END:   next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   // Command outputs are registered from next_state so the bus shows the
   // command of the state being entered, with no combinational path out.
   always_comb begin
      cmd_d  = CMD_NOP;
      bank_d = 2'b11;
      addr_d = 13'h1fff;
      case (next_state)
         S_ACT: begin
            cmd_d  = CMD_ACT;
            bank_d = addr_q[23:22];
            addr_d = addr_q[21:9];
         end
         S_READ: begin
            cmd_d  = CMD_RD;
            bank_d = addr_q[23:22];
            addr_d = {4'b0000, addr_q[8:0]};
         end
         S_PRE: begin
            cmd_d  = CMD_PRE;
            bank_d = addr_q[23:22];
            addr_d = 13'h0000;
         end
         default: ;
      endcase
   end

   always_ff @(posedge rd_clk) begin
      if (!rd_rst_n) begin
         state   <= S_IDLE;
         cnt     <= '0;
         addr_q  <= '0;
         rd_cmd  <= CMD_NOP;
         rd_bank <= '1;
         rd_addr <= '1;
         rd_req  <= 1'b0;
         rd_end  <= 1'b0;
         rd_busy <= 1'b0;
      end else begin
         state <= next_state;
         cnt   <= (counting && (next_state == state)) ? cnt + 10'd1 : '0;
         if ((state == S_IDLE) && (next_state == S_REQ)) begin
            addr_q <= rd_addr_in;
         end
         rd_cmd  <= cmd_d;
         rd_bank <= bank_d;
         rd_addr <= addr_d;
         rd_req  <= (state == S_REQ) && !grant;
         rd_end  <= (next_state == S_END);
         rd_busy <= (next_state != S_IDLE);
      end
   end

   // Capture path runs on its own: a CAS-latency shift register marks the
   // cycle word 0 is on dq, then the valid counter covers the remaining words.
   assign cap_en = lat_sr[CAS_LAT-1] || (vld_cnt != '0);

   always_ff @(posedge rd_clk) begin
      if (!rd_rst_n) begin
         lat_sr        <= '0;
         vld_cnt       <= '0;
         rd_data_valid <= 1'b0;
         rd_data       <= '0;
      end else begin
         lat_sr <= {lat_sr[CAS_LAT-2:0], (state == S_READ)};
         if (lat_sr[CAS_LAT-1]) begin
            vld_cnt <= VLD_LOAD;
         end else if (vld_cnt != '0) begin
            vld_cnt <= vld_cnt - 10'd1;
         end
         rd_data_valid <= cap_en;
         if (cap_en) begin
            rd_data <= sdram_dq_in;
         end
      end
   end

endmodule

// File: tb/tb_sdram_rd.sv
// -----------------------------------------------------------------------------
// tb_sdram_rd
// Three sdram_rd instances (defaults; CL2/BL1; BL512) share clock, reset and
// init_end. A small full-page SDRAM model per instance answers READ commands
// (truncated by PRECHARGE). Stimulus pushes the expected words into a
// scoreboard queue; a negedge monitor pops and compares on rd_data_valid.
// -----------------------------------------------------------------------------
module tb_sdram_rd;

   localparam int unsigned NI = 3;
   localparam int unsigned CL_A      [NI] = '{3, 2, 3};
   localparam int unsigned BL_A      [NI] = '{8, 1, 512};
   // READ-to-rd_end distance: BL + max(TRP, CL+1) = 8+4, 1+3, 512+4
   localparam int unsigned END_OFS_A [NI] = '{12, 4, 516};
   localparam int unsigned TRCD_P = 2;
   localparam int unsigned TRP_P  = 2;

   localparam logic [3:0] C_NOP = 4'b0111;
   localparam logic [3:0] C_ACT = 4'b0011;
   localparam logic [3:0] C_RD  = 4'b0101;
   localparam logic [3:0] C_PRE = 4'b0010;

   typedef struct {
      int unsigned inst;
      int unsigned k;
      logic [15:0] word;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   logic init_end;

   logic [NI-1:0]        trig, en, req, rend, dvalid, busy;
   logic [NI-1:0][23:0]  addr_in;
   logic [NI-1:0][15:0]  dq, data;
   logic [NI-1:0][3:0]   cmd;
   logic [NI-1:0][1:0]   bank;
   logic [NI-1:0][12:0]  addr;

   exp_t        sbq [$];
   int unsigned errors = 0;
   int unsigned checks = 0;
   int unsigned cyc    = 0;

   int unsigned t0_obs [NI];
   int unsigned vcount [NI];
   logic        m_on   [NI];
   logic [1:0]  m_bank [NI];
   logic [12:0] m_row  [NI];
   logic [8:0]  m_col  [NI];
   logic [16:0] pipe   [NI][5];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      sdram_rd #(
         .CAS_LAT  (CL_A[gi]),
         .TRCD     (TRCD_P),
         .TRP      (TRP_P),
         .BURST_LEN(BL_A[gi])
      ) u_dut (
         .rd_clk       (clk),
         .rd_rst_n     (rst_n),
         .init_end     (init_end),
         .rd_trig      (trig[gi]),
         .rd_addr_in   (addr_in[gi]),
         .rd_en        (en[gi]),
         .sdram_dq_in  (dq[gi]),
         .rd_req       (req[gi]),
         .rd_end       (rend[gi]),
         .rd_cmd       (cmd[gi]),
         .rd_bank      (bank[gi]),
         .rd_addr      (addr[gi]),
         .rd_data      (data[gi]),
         .rd_data_valid(dvalid[gi]),
         .rd_busy      (busy[gi])
      );
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_reset_vals(input int unsigned g, input string tag);
      string p;
      p = $sformatf("%s_i%0d", tag, g);
      chk({p, "_cmd"},   cmd[g],    C_NOP);
      chk({p, "_bank"},  bank[g],   2'b11);
      chk({p, "_addr"},  addr[g],   13'h1fff);
      chk({p, "_req"},   req[g],    1'b0);
      chk({p, "_end"},   rend[g],   1'b0);
      chk({p, "_busy"},  busy[g],   1'b0);
      chk({p, "_valid"}, dvalid[g], 1'b0);
      chk({p, "_data"},  data[g],   16'h0000);
   endtask

   // SDRAM model plus scoreboard monitor; everything sampled mid-cycle.
   always @(negedge clk) begin : mon
      exp_t e;
      for (int unsigned g = 0; g < NI; g++) begin
         if (!rst_n) begin
            m_on[g] = 1'b0;
            m_col[g] = '0;
            for (int unsigned j = 0; j < 5; j++) pipe[g][j] = '0;
         end else begin
            case (cmd[g])
               C_ACT: begin
                  m_bank[g] = bank[g];
                  m_row[g]  = addr[g];
               end
               C_RD: begin
                  m_on[g]   = 1'b1;
                  m_col[g]  = addr[g][8:0];
                  t0_obs[g] = cyc;
               end
               C_PRE: m_on[g] = 1'b0;
               default: if (m_on[g]) m_col[g] = m_col[g] + 9'd1;
            endcase
            for (int unsigned j = 4; j > 0; j--) pipe[g][j] = pipe[g][j-1];
            pipe[g][0] = {m_on[g], m_bank[g], m_row[g][4:0], m_col[g]};
         end
         dq[g] = pipe[g][CL_A[g]][16] ? pipe[g][CL_A[g]][15:0] : 16'hDEAD;

         if (dvalid[g]) begin
            vcount[g]++;
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_valid_i%0d: got valid with data %0h, required no valid (t=%0t)",
                        g, data[g], $time);
            end else begin
               e = sbq.pop_front();
               chk($sformatf("sb_inst_k%0d", e.k), g, e.inst);
               chk($sformatf("sb_data_i%0d_k%0d", g, e.k), data[g], e.word);
               chk($sformatf("sb_cycle_i%0d_k%0d", g, e.k), cyc, t0_obs[g] + CL_A[g] + 1 + e.k);
            end
         end
      end
   end

   task automatic run_read(input int unsigned g, input logic [23:0] a,
                           input int unsigned gdly, input bit retrig, input bit abort);
      int unsigned bl, r_rd, r_pre, r_end, vbefore;
      logic [1:0]  b;
      logic [12:0] row;
      logic [8:0]  col;
      logic [3:0]  ecmd;
      logic [1:0]  ebank;
      logic [12:0] eaddr;
      exp_t        e;
      string       tg;
      bl      = BL_A[g];
      b       = a[23:22];
      row     = a[21:9];
      col     = a[8:0];
      r_rd    = 1 + TRCD_P;
      r_pre   = r_rd + bl;
      r_end   = r_rd + END_OFS_A[g];
      vbefore = vcount[g];
      tg      = $sformatf("i%0d_a%06h", g, a);

      addr_in[g] = a;
      trig[g]    = 1'b1;
      if (!abort) begin
         for (int unsigned k = 0; k < bl; k++) begin
            e.inst = g;
            e.k    = k;
            e.word = {b, row[4:0], 9'(col + k)};
            sbq.push_back(e);
         end
      end
      @(negedge clk);
      trig[g] = 1'b0;
      chk({tg, "_busy_start"}, busy[g], 1'b1);
      chk({tg, "_req_early"},  req[g],  1'b0);
      @(negedge clk);
      for (int unsigned i = 0; i < gdly; i++) begin
         chk($sformatf("%s_req_wait%0d", tg, i), req[g], 1'b1);
         chk($sformatf("%s_cmd_wait%0d", tg, i), cmd[g], C_NOP);
         @(negedge clk);
      end
      chk({tg, "_req_at_grant"}, req[g], 1'b1);
      en[g] = 1'b1;

      for (int unsigned r = 1; r <= r_end + 1; r++) begin
         @(negedge clk);
         trig[g]    = retrig && (r == 2);
         addr_in[g] = (retrig && (r == 2)) ? ~a : a;
         ecmd  = C_NOP;
         ebank = 2'b11;
         eaddr = 13'h1fff;
         if (r == 1) begin
            ecmd = C_ACT; ebank = b; eaddr = row;
         end else if (r == r_rd) begin
            ecmd = C_RD; ebank = b; eaddr = {4'b0000, col};
         end else if (r == r_pre) begin
            ecmd = C_PRE; ebank = b; eaddr = 13'h0000;
         end
         chk($sformatf("%s_cmd_r%0d", tg, r),  cmd[g],  ecmd);
         chk($sformatf("%s_bank_r%0d", tg, r), bank[g], ebank);
         chk($sformatf("%s_addr_r%0d", tg, r), addr[g], eaddr);
         chk($sformatf("%s_end_r%0d", tg, r),  rend[g], (r == r_end));
         chk($sformatf("%s_req_r%0d", tg, r),  req[g],  1'b0);
         chk($sformatf("%s_busy_r%0d", tg, r), busy[g], (r <= r_end));
         if (abort && (r == r_rd + 3)) begin
            rst_n = 1'b0;
            en[g] = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            chk_reset_vals(g, "abort");
            repeat (10) @(negedge clk);
            chk({tg, "_abort_no_valid"}, vcount[g], vbefore);
            return;
         end
      end
      en[g] = 1'b0;
      for (int unsigned i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("%s_no_req_after%0d", tg, i), req[g], 1'b0);
      end
      chk({tg, "_words_seen"}, vcount[g] - vbefore, bl);
      chk({tg, "_sb_drained"}, sbq.size(), 0);
   endtask

   initial begin
      rst_n    = 1'b0;
      init_end = 1'b0;
      trig     = '0;
      en       = '0;
      addr_in  = '0;
      for (int unsigned g = 0; g < NI; g++) vcount[g] = 0;
      repeat (3) @(negedge clk);
      for (int unsigned g = 0; g < NI; g++) chk_reset_vals(g, "reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Request before initialisation completes must be dropped.
      trig[0]    = 1'b1;
      addr_in[0] = 24'h12_3456;
      @(negedge clk);
      trig[0] = 1'b0;
      for (int unsigned i = 0; i < 5; i++) begin
         chk($sformatf("noinit_req%0d", i),  req[0],  1'b0);
         chk($sformatf("noinit_busy%0d", i), busy[0], 1'b0);
         @(negedge clk);
      end
      init_end = 1'b1;
      @(negedge clk);

      run_read(0, 24'h40_0205, 3, 1'b1, 1'b0);
      run_read(0, 24'hC1_2345, 20, 1'b0, 1'b0);
      run_read(1, 24'h2A_BCDE, 1, 1'b0, 1'b0);
      run_read(2, {2'b10, 13'h0ABC, 9'h1F0}, 2, 1'b0, 1'b0);
      run_read(0, 24'h55_AA11, 2, 1'b0, 1'b1);
      run_read(0, 24'h81_00FF, 2, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, required completion earlier");
      $fatal(1, "watchdog expired");
   end

endmodule
